// File: rtl/wb_slv_lbus_bridge.sv
// Wishbone classic slave to local-bus bridge with rdy_in wait states
// and a bounded wait that ends a hung access in a Wishbone error.
module wb_slv_lbus_bridge #(
    parameter int          ADDR_W       = 8,
    parameter int          DATA_W       = 32,
    parameter int          WAIT_MAX     = 15,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   sel_i,
    input  logic [31:0]           adr_i,
    input  logic [DATA_W-1:0]     dat_i,
    output logic [DATA_W-1:0]     dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  wr_out,
    output logic                  rd_out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [DATA_W/8-1:0]   be_out,
    output logic [DATA_W-1:0]     data_out,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  rdy_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int                  CNT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [DATA_W-1:0]   TO_DATA = DATA_W'(TIMEOUT_DATA);

    logic [1:0]       state;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             unused_adr;

    assign unused_adr = ^adr_i[31:ADDR_W];

    // The last permitted wait cycle; WAIT_MAX=0 disables the timeout entirely.
    assign timeout = (WAIT_MAX > 0) && (wait_cnt == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            dat_o    <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            wr_out   <= 1'b0;
            rd_out   <= 1'b0;
            addr_out <= '0;
            be_out   <= '0;
            data_out <= '0;
        end else begin
            // NOTE: pulse outputs default low here so every branch below
            // only has to raise them; the last non-blocking write wins.
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            wr_out <= 1'b0;
            rd_out <= 1'b0;

            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (cyc_i && stb_i) begin
                        addr_out <= adr_i[ADDR_W-1:0];
                        be_out   <= sel_i;
                        data_out <= dat_i;
                        we_q     <= we_i;
                        if (sel_i != '0) begin
                            wr_out <= we_i;
                            rd_out <= !we_i;
                            state  <= ST_WAIT;
                        end else begin
                            // Nothing to transfer: complete without touching the local bus.
                            ack_o <= 1'b1;
                            state <= ST_RESP;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!cyc_i) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (rdy_in) begin
                        if (!we_q) dat_o <= data_in;
                        ack_o    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_RESP;
                    end else if (timeout) begin
                        if (!we_q) dat_o <= TO_DATA;
                        err_o    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slv_lbus_bridge.sv
// Randomised transaction-level bench for wb_slv_lbus_bridge; each access
// is predicted from its wait count and compared cycle by cycle.
module tb_wb_slv_lbus_bridge;

    localparam int          WAIT_MAX = 15;
    localparam logic [31:0] TO_DATA  = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic [31:0] adr_i = '0, dat_i = '0;
    logic [31:0] dat_o;
    logic        ack_o, err_o, wr_out, rd_out;
    logic [7:0]  addr_out;
    logic [3:0]  be_out;
    logic [31:0] data_out;
    logic [31:0] data_in = '0;
    logic        rdy_in = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_dat = '0;

    wb_slv_lbus_bridge #(
        .ADDR_W(8), .DATA_W(32), .WAIT_MAX(WAIT_MAX), .TIMEOUT_DATA(TO_DATA)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .err_o(err_o), .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out),
        .be_out(be_out), .data_out(data_out), .data_in(data_in), .rdy_in(rdy_in)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (caller is mid-cycle). The device holds rdy_in low for
    // w wait cycles; with do_abort the master drops cyc_i somewhere in WAIT.
    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] wdat, input int w, input bit do_abort);
        int          exp_k, abort_at, done_k, strobe_n, strobe_k;
        logic        got_err, got_both, strobe_wr, aborted;
        logic [31:0] rd_val;

        if (sel == 4'h0)                      begin exp_k = 1;            got_err = 1'b0; end
        else if (WAIT_MAX > 0 && w >= WAIT_MAX) begin exp_k = WAIT_MAX + 1; got_err = 1'b1; end
        else                                  begin exp_k = w + 2;        got_err = 1'b0; end
        aborted  = do_abort && (sel != 4'h0);
        abort_at = aborted ? $urandom_range(1, exp_k - 1) : 0;

        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = wdat;
        rdy_in = 1'($urandom); data_in = $urandom;

        done_k = 0; strobe_n = 0; strobe_k = 0; strobe_wr = 1'b0; rd_val = '0;
        got_both = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk_i); #1;
            if (wr_out || rd_out) begin
                strobe_n++; strobe_k = k; strobe_wr = wr_out;
            end
            if (k == 1 && sel != 4'h0) begin
                check("addr_out", 32'(addr_out), 32'(adr[7:0]));
                check("be_out",   32'(be_out),   32'(sel));
                check("data_out", data_out,      wdat);
            end
            if (ack_o || err_o) begin
                done_k = k; got_both = ack_o && err_o;
                check("is_err", 32'(err_o), 32'(got_err && !aborted));
                break;
            end
            if (aborted && k >= abort_at + 3) break;
            rdy_in  = (k > w);
            data_in = $urandom;
            if (k == w + 1) rd_val = data_in;
            if (aborted && k == abort_at) begin cyc_i = 1'b0; stb_i = 1'b0; end
        end

        check("strobe_cnt", 32'(strobe_n), (sel != 4'h0) ? 32'd1 : 32'd0);
        if (sel != 4'h0) begin
            check("strobe_cyc", 32'(strobe_k), 32'd1);
            check("strobe_dir", 32'(strobe_wr), 32'(we));
        end
        check("ack_err_both", 32'(got_both), 32'd0);

        if (aborted) begin
            check("abort_noresp", 32'(done_k), 32'd0);
        end else begin
            check("done_cycle", 32'(done_k), 32'(exp_k));
            if (!we && sel != 4'h0) exp_dat = got_err ? TO_DATA : rd_val;
        end
        check("dat_o", dat_o, exp_dat);

        if (!aborted) begin
            // RESP exit edge: request still held, must not be taken or re-acked.
            @(posedge clk_i); #1;
            check("post_resp_quiet", 32'({ack_o, err_o, wr_out, rd_out}), 32'd0);
        end
    endtask

    task automatic idle_cycle();
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_quiet", 32'({ack_o, err_o, wr_out, rd_out}), 32'd0);
    endtask

    initial begin
        logic       r_we;
        logic [3:0] r_sel;
        int         r_w;

        #12;
        check("rst_dat_o", dat_o, 32'd0);
        check("rst_pulses", 32'({ack_o, err_o, wr_out, rd_out}), 32'd0);
        check("rst_local", 32'({addr_out, be_out}), 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Directed cases: zero-wait write, 3-wait read, timeout read, sel=0, back-to-back reads.
        run_txn(1'b1, 4'hF, 32'h0000_0104, 32'h1234_5678, 0, 1'b0);
        idle_cycle();
        run_txn(1'b0, 4'hF, 32'h0000_0020, 32'h0, 3, 1'b0);
        idle_cycle();
        run_txn(1'b0, 4'hF, 32'h0000_0030, 32'h0, 40, 1'b0);
        run_txn(1'b1, 4'h0, 32'h0000_0040, 32'h5555_AAAA, 0, 1'b0);
        run_txn(1'b0, 4'h3, 32'h0000_0050, 32'h0, 0, 1'b0);
        run_txn(1'b0, 4'hC, 32'h0000_0054, 32'h0, 1, 1'b0);
        run_txn(1'b0, 4'hF, 32'h0000_0058, 32'h0, 10, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r_we  = 1'($urandom);
            r_sel = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r_w   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(13, 20);
            run_txn(r_we, r_sel, $urandom, $urandom, r_w, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // Asynchronous reset in the middle of a wait.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 32'h77; rdy_in = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("amid_rst_dat_o", dat_o, 32'd0);
        check("amid_rst_pulses", 32'({ack_o, err_o, wr_out, rd_out}), 32'd0);
        check("amid_rst_local", 32'({addr_out, be_out}), 32'd0);
        check("amid_rst_data_out", data_out, 32'd0);
        exp_dat = '0;
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        run_txn(1'b1, 4'hF, 32'h0000_0104, 32'h1234_5678, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
